// File: rtl/arch_maptable_pkg.sv
// Shared processor constants and types for the architectural map table.
// Consumed by arch_maptable, retire_fwd and their bench.
package arch_maptable_pkg;

    localparam int MAP_WAYS   = 3;
    localparam int MAP_PR_W   = 6;
    localparam int MAP_AR_NUM = 32;
    localparam int MAP_AR_W   = 5;

    typedef logic [MAP_PR_W-1:0] pr_idx_t;
    typedef pr_idx_t [MAP_WAYS-1:0] pr_vec_t;

    function automatic logic [31:0] popcount(input logic [31:0] v);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/arch_maptable_retire_fwd.sv
// Per-way retire forwarding: computes Told for every way and the
// post-retire map, with younger same-AR ways overriding older ones.
module retire_fwd
    import arch_maptable_pkg::*;
#(
    parameter int WAYS   = MAP_WAYS,
    parameter int PR_W   = MAP_PR_W,
    parameter int AR_NUM = MAP_AR_NUM
) (
    input  logic [WAYS-1:0]                en,
    input  logic [WAYS-1:0][4:0]           ar,
    input  logic [WAYS-1:0][PR_W-1:0]      pr,
    input  logic [AR_NUM-1:0][PR_W-1:0]    map_cur,
    output logic [WAYS-1:0][PR_W-1:0]      told,
    output logic [WAYS-1:0]                told_valid,
    output logic [AR_NUM-1:0][PR_W-1:0]    map_next
);

    // Ascending scan of older ways lets the youngest matching way win.
    always_comb begin
        told       = '0;
        told_valid = '0;
        for (int k = 0; k < WAYS; k++) begin
            if (en[k] && (ar[k] != 5'd0) && (int'(ar[k]) < AR_NUM)) begin
                told_valid[k] = 1'b1;
                told[k]       = map_cur[ar[k]];
                for (int j = 0; j < k; j++) begin
                    if (en[j] && (ar[j] == ar[k])) begin
                        told[k] = pr[j];
                    end
                end
            end
        end
    end

    // Later (younger) ways overwrite earlier writes to the same AR.
    always_comb begin
        map_next = map_cur;
        for (int k = 0; k < WAYS; k++) begin
            if (en[k] && (ar[k] != 5'd0) && (int'(ar[k]) < AR_NUM)) begin
                map_next[ar[k]] = pr[k];
            end
        end
    end

endmodule

// File: rtl/arch_maptable.sv
// Committed architectural-to-physical register map updated at retire.
// Optional debug ports (array_display, retire_count) under ARCH_MAP_DISPLAY_EN.
module arch_maptable
    import arch_maptable_pkg::*;
#(
    parameter int WAYS   = MAP_WAYS,
    parameter int PR_W   = MAP_PR_W,
    parameter int AR_NUM = MAP_AR_NUM
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [WAYS-1:0]                RetireEN,
    input  logic [WAYS-1:0][4:0]           RetireAR,
    input  logic [WAYS-1:0][PR_W-1:0]      RetirePR,
    output logic [WAYS-1:0][PR_W-1:0]      RetireTold,
    output logic [WAYS-1:0]                ToldValid,
`ifdef ARCH_MAP_DISPLAY_EN
    output logic [AR_NUM-1:0][PR_W-1:0]    array_display,
    output logic [31:0]                    retire_count,
`endif
    output logic [AR_NUM-1:0][PR_W-1:0]    ArchMap
);

    logic [AR_NUM-1:0][PR_W-1:0] map_q;
    logic [AR_NUM-1:0][PR_W-1:0] map_next;
    logic [AR_NUM-1:0][PR_W-1:0] map_ident;
    logic [WAYS-1:0]             en_gated;

    // Retires arriving alongside reset are dropped entirely.
    assign en_gated = reset ? '0 : RetireEN;

    always_comb begin
        map_ident = '0;
        for (int i = 0; i < AR_NUM; i++) begin
            map_ident[i] = PR_W'(i);
        end
    end

    retire_fwd #(
        .WAYS   (WAYS),
        .PR_W   (PR_W),
        .AR_NUM (AR_NUM)
    ) u_retire_fwd (
        .en         (en_gated),
        .ar         (RetireAR),
        .pr         (RetirePR),
        .map_cur    (map_q),
        .told       (RetireTold),
        .told_valid (ToldValid),
        .map_next   (map_next)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            map_q <= map_ident;
        end else begin
            map_q <= map_next;
        end
    end

    assign ArchMap = reset ? map_ident : map_next;

`ifdef ARCH_MAP_DISPLAY_EN
    assign array_display = map_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            retire_count <= '0;
        end else begin
            retire_count <= retire_count + popcount(32'(ToldValid));
        end
    end
`endif

endmodule

// File: doc/arch_maptable.md
ARCH_MAPTABLE -- requirements
Module: arch_maptable

Interface
REQ-001 SHALL have parameter WAYS, default 3: retire width.
REQ-002 SHALL have parameter PR_W, default 6: physical register index width, 64 PRs.
REQ-003 SHALL have parameter AR_NUM, default 32: architectural register count.
REQ-004 SHALL have port clock, input, 1: single clock; all state updates on its posedge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port RetireEN, input, WAYS: per-way retire valid from ROB; way 0 is oldest.
REQ-007 SHALL have port RetireAR, input, WAYS x 5: destination architectural register per way.
REQ-008 SHALL have port RetirePR, input, WAYS x PR_W: new PR (Tnew) per way.
REQ-009 SHALL have port RetireTold, output, WAYS x PR_W: previous mapping (Told) per way, driven to Freelist RetireReg.
REQ-010 SHALL have port ToldValid, output, WAYS: Told is to be freed, driven to Freelist RetireEN.
REQ-011 SHALL have port ArchMap, output, AR_NUM x PR_W: committed map including this cycle's retires, for RAT recovery on BPRecoverEN.

Function
REQ-012 SHALL hold a registered table of AR_NUM entries, each PR_W wide.
REQ-013 SHALL compute RetireTold and ToldValid combinationally in the same cycle as RetireEN; zero-cycle latency.
REQ-014 SHALL set ToldValid[k] = RetireEN[k] AND RetireAR[k] != 0; AR 0 retires are no-ops: no free, no table write.
REQ-015 SHALL drive RetireTold[k] = RetirePR[j] for the youngest way j < k with RetireEN[j], matching AR, AR != 0; otherwise table[RetireAR[k]].
REQ-016 SHALL drive RetireTold[k] = 0 when ToldValid[k] = 0.
REQ-017 SHALL write table[AR] <= RetirePR of the youngest enabled way naming that AR (AR != 0) at posedge; older same-AR writes are discarded.
REQ-018 SHALL treat non-contiguous RetireEN (e.g. 3'b101) per bit, with identical rules.
REQ-019 SHALL drive ArchMap[i] = value table[i] will hold after this posedge (table plus REQ-017 forwarding).
REQ-020 SHALL keep table[0] constant at 0.
REQ-021 SHALL NOT check Tnew uniqueness; duplicate PRs are an upstream error.

Reset
REQ-022 SHALL load table[i] = i for all i on reset, complementing Freelist reset contents PR 32..63.
REQ-023 SHALL ignore RetireEN while reset is high and SHALL drive ToldValid = 0 in that cycle.
REQ-024 SHALL, on reset asserted mid-operation, discard same-cycle retires; the table equals identity after that edge.

Configuration
REQ-025 SHALL, with ARCH_MAP_DISPLAY_EN defined, add output array_display (AR_NUM x PR_W, registered table) and output retire_count (32-bit, reset 0, += popcount(ToldValid) per cycle).
REQ-026 SHALL, without ARCH_MAP_DISPLAY_EN, omit both ports and counter; functional outputs are identical.

Structure
REQ-027 SHALL place WAYS, PR_W, AR_NUM constants and the typedef for a PR index vector in the shared processor package.
REQ-028 SHALL implement the per-way forwarding/priority logic as one sub-module, retire_fwd, instantiated once for all ways.

Verification
REQ-029 SHALL cover: reset; RetireEN=000 -> ArchMap[i]=i, ToldValid=000.
REQ-030 SHALL cover: RetireEN=001, AR=5, PR=40 -> Told[0]=5, ToldValid=001; next cycle ArchMap[5]=40.
REQ-031 SHALL cover: RetireEN=111, AR={3,3,3}, PR={33,34,35} -> Told={3,33,34}; next ArchMap[3]=35.
REQ-032 SHALL cover: RetireEN=111, AR={0,7,0}, PR={40,41,42} -> ToldValid=010, Told[1]=7; ArchMap[0] stays 0.
REQ-033 SHALL cover: RetireEN=101, AR={9,x,9}, PR={50,x,51} -> Told[2]=50, ArchMap[9]=51 in the same cycle.
REQ-034 SHALL cover: reset asserted with RetireEN=111 -> ToldValid=000; table equals identity next cycle.
